// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single-port VRAM between the gfx fetcher (absolute priority) and the CPU req/ack bus.
// Define VRAM_WRBUF_EN to add a WRBUF_DEPTH-entry posted-write FIFO in front of the port.
module vram_arbiter #(
    parameter int WRBUF_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        gfx_req_i,
    input  logic [13:0] gfx_vaddr_i,
    output logic [15:0] gfx_vdata_o,
    input  logic        cpu_req_i,
    input  logic        cpu_wr_i,
    input  logic [13:0] cpu_addr_i,
    input  logic [15:0] cpu_wrdata_i,
    input  logic [1:0]  cpu_bytesel_i,
    output logic        cpu_ack_o,
    output logic [15:0] cpu_rddata_o,
    output logic [13:0] ram_addr_o,
    output logic [15:0] ram_wrdata_o,
    output logic [1:0]  ram_wren_o,
    input  logic [15:0] ram_rddata_i
);
    typedef enum logic [1:0] {IDLE, GRANT, ACK} state_e;

    state_e      state_q, state_d;
    logic [15:0] rddata_q;
    logic        wb_en, wb_push, wb_pop, wb_empty, rd_go, grant;
    logic [13:0] wb_addr;
    logic [15:0] wb_data;
    logic [1:0]  wb_be;

    if (WRBUF_DEPTH < 2 || (WRBUF_DEPTH & (WRBUF_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("WRBUF_DEPTH must be a power of 2 and at least 2");
    end

`ifdef VRAM_WRBUF_EN
    localparam int AW = $clog2(WRBUF_DEPTH);
    logic [AW:0] wptr_q, rptr_q;
    logic        wb_full;
    logic [13:0] addr_q [WRBUF_DEPTH];
    logic [15:0] data_q [WRBUF_DEPTH];
    logic [1:0]  be_q   [WRBUF_DEPTH];
    assign wb_en    = 1'b1;
    assign wb_empty = wptr_q == rptr_q;
    assign wb_full  = wptr_q == {~rptr_q[AW], rptr_q[AW-1:0]};
    // writes bypass GRANT: they are acked as soon as they land in the FIFO
    assign wb_push  = state_q == IDLE && cpu_req_i && cpu_wr_i && !wb_full;
    assign wb_pop   = !gfx_req_i && !wb_empty;
    assign wb_addr  = addr_q[rptr_q[AW-1:0]];
    assign wb_data  = data_q[rptr_q[AW-1:0]];
    assign wb_be    = be_q[rptr_q[AW-1:0]];
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (wb_push) wptr_q <= wptr_q + (AW+1)'(1);
            if (wb_pop) rptr_q <= rptr_q + (AW+1)'(1);
        end
    end
    always_ff @(posedge clk_i) begin
        if (wb_push) begin
            addr_q[wptr_q[AW-1:0]] <= cpu_addr_i;
            data_q[wptr_q[AW-1:0]] <= cpu_wrdata_i;
            be_q[wptr_q[AW-1:0]]   <= cpu_bytesel_i;
        end
    end
`else
    assign wb_en    = 1'b0;
    assign wb_empty = 1'b1;
    assign wb_push  = 1'b0;
    assign wb_pop   = 1'b0;
    assign wb_addr  = '0;
    assign wb_data  = '0;
    assign wb_be    = '0;
`endif

    // reads (and unbuffered writes) only start when the port is free and no posted write is pending
    assign rd_go = cpu_req_i && !gfx_req_i && wb_empty && !(wb_en && cpu_wr_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q == IDLE  ? (wb_push ? ACK : rd_go ? GRANT : IDLE) :
                  state_q == GRANT ? (gfx_req_i ? GRANT : ACK) : IDLE;
    end

    always_comb begin
        grant        = state_q == GRANT && !gfx_req_i;
        ram_addr_o   = wb_pop ? wb_addr : grant ? cpu_addr_i : gfx_vaddr_i;
        ram_wrdata_o = wb_pop ? wb_data : cpu_wrdata_i;
        ram_wren_o   = wb_pop ? wb_be : (grant && cpu_wr_i) ? cpu_bytesel_i : 2'b00;
        cpu_ack_o    = state_q == ACK;
        // read data arrives with the ack, so it is passed through on that cycle and held afterwards
        cpu_rddata_o = (state_q == ACK && !cpu_wr_i) ? ram_rddata_i : rddata_q;
        gfx_vdata_o  = ram_rddata_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rddata_q <= '0;
        else if (state_q == ACK && !cpu_wr_i) rddata_q <= ram_rddata_i;
    end
endmodule
